// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - state_e : arbiter FSM encoding (IDLE, ACCESS, DONE)
//   - OWNER_A / OWNER_B : one-bit requester IDs used for grants and the RR pointer
//   - other_owner() : the opposite requester ID, used to advance the RR pointer
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  function automatic logic other_owner(input logic owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection between requesters A and B.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin on contention; when
// undefined, A always wins contention and the pointer input is ignored).
// Ports:
//   a_req_i, b_req_i : pending requests
//   ptr_i            : round-robin pointer (port favoured on contention)
//   winner_o         : granted owner ID (OWNER_A when nobody requests)
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic ptr_i,
  output logic winner_o
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: a lone requester wins, contention goes to the pointer's port.
  always_comb begin
    if (a_req_i && b_req_i) begin
      winner_o = ptr_i;
    end else if (b_req_i) begin
      winner_o = OWNER_B;
    end else begin
      winner_o = OWNER_A;
    end
  end
`else
  // Fixed priority never looks at the pointer.
  logic unused_ptr_s;
  assign unused_ptr_s = ptr_i;

  // Fixed priority: B only wins when A is not requesting.
  always_comb begin
    if (b_req_i && !a_req_i) begin
      winner_o = OWNER_B;
    end else begin
      winner_o = OWNER_A;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between port A (core LSU)
// and port B (debug/DMA loader). Each grant runs IDLE -> ACCESS -> DONE: the
// winner's request is latched in IDLE, the memory is driven during ACCESS and
// the owner gets a one-cycle ack (with read data) in DONE.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin contention resolution;
// default build is fixed priority with port A winning).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   A_*/B_* req/we/addr/wdata    : requester inputs, held until ack
//   A_*/B_* ack/rdata            : one-cycle completion pulse and read data
//   DMEM_address/data_in/mem_write/mem_read : memory drive, zero outside ACCESS
//   DMEM_data_out                : combinational memory read data
//   busy                         : FSM not in IDLE
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A_req,
  input  logic              A_we,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0] A_wdata,
  output logic              A_ack,
  output logic [DATA_W-1:0] A_rdata,
  input  logic              B_req,
  input  logic              B_we,
  input  logic [ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0] B_wdata,
  output logic              B_ack,
  output logic [DATA_W-1:0] B_rdata,
  output logic [ADDR_W-1:0] DMEM_address,
  output logic [DATA_W-1:0] DMEM_data_in,
  output logic              DMEM_mem_write,
  output logic              DMEM_mem_read,
  input  logic [DATA_W-1:0] DMEM_data_out,
  output logic              busy
);

  state_e              state_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;
  logic                ptr_s;
  logic                winner_s;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;
  assign ptr_s = ptr_q;
`else
  assign ptr_s = OWNER_A;
`endif

  dmem_arb_pick u_pick (
    .a_req_i  (A_req),
    .b_req_i  (B_req),
    .ptr_i    (ptr_s),
    .winner_o (winner_s)
  );

  // FSM, request latches, acks and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q     <= OWNER_A;
`endif
    end else begin
      // Acks are single-cycle: only the ACCESS->DONE edge raises one.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (A_req || B_req) begin
            state_q <= ACCESS;
            owner_q <= winner_s;
            if (winner_s == OWNER_B) begin
              we_q    <= B_we;
              addr_q  <= B_addr;
              wdata_q <= B_wdata;
            end else begin
              we_q    <= A_we;
              addr_q  <= A_addr;
              wdata_q <= A_wdata;
            end
`ifdef DMEM_ARB_RR_EN
            ptr_q <= other_owner(winner_s);
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= DONE;
          if (owner_q == OWNER_B) begin
            b_ack_q <= 1'b1;
            if (!we_q) begin
              b_rdata_q <= DMEM_data_out;
            end else begin
              b_rdata_q <= b_rdata_q;
            end
          end else begin
            a_ack_q <= 1'b1;
            if (!we_q) begin
              a_rdata_q <= DMEM_data_out;
            end else begin
              a_rdata_q <= a_rdata_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory drive: only the ACCESS cycle touches the memory. Write is gated by
  // rst directly so a reset landing in ACCESS cannot commit a partial write.
  always_comb begin
    DMEM_address   = '0;
    DMEM_data_in   = '0;
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;
    if (state_q == ACCESS) begin
      DMEM_address   = addr_q;
      DMEM_data_in   = wdata_q;
      DMEM_mem_write = we_q & ~rst;
      DMEM_mem_read  = ~we_q;
    end else begin
      DMEM_mem_write = 1'b0;
      DMEM_mem_read  = 1'b0;
    end
  end

  assign A_ack   = a_ack_q;
  assign B_ack   = b_ack_q;
  assign A_rdata = a_rdata_q;
  assign B_rdata = b_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule
